alu_ctrl_dec: RTL and testbench

Registered decode stage that converts RV32I instruction words into the 5-bit ALUop code the ALU consumes, plus side-band control (immediate select, branch flag, illegal flag). It sits between instruction fetch and the execute stage's ALU. A valid/ready handshake on both sides and a 2-entry output queue absorb execute-side stalls without losing instructions.

---
 rtl/alu_ctrl_dec.sv | 167 ++++++++++++++++
 tb/tb_alu_ctrl_dec.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_dec.sv
// RV32I -> ALUop decode stage with a 2-entry output queue.
// Decode is combinational on the incoming word; the queue holds decoded side-band only.
module alu_ctrl_dec #(
    parameter int DEPTH = 2,
    parameter int OPW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_alu_op,
    output logic            out_use_imm,
    output logic            out_is_branch,
    output logic            out_illegal
);
    localparam int EW = OPW + 3;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_AUI  = 7'b0010111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
    localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
    localparam logic [OPW-1:0] ALU_SLL  = OPW'(2);
    localparam logic [OPW-1:0] ALU_SLT  = OPW'(3);
    localparam logic [OPW-1:0] ALU_SLTU = OPW'(4);
    localparam logic [OPW-1:0] ALU_XOR  = OPW'(5);
    localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
    localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
    localparam logic [OPW-1:0] ALU_OR   = OPW'(8);
    localparam logic [OPW-1:0] ALU_AND  = OPW'(9);
    localparam logic [OPW-1:0] ALU_BEQ  = OPW'(10);
    localparam logic [OPW-1:0] ALU_BNE  = OPW'(11);
    localparam logic [OPW-1:0] ALU_BLT  = OPW'(12);
    localparam logic [OPW-1:0] ALU_BGE  = OPW'(13);
    localparam logic [OPW-1:0] ALU_BLTU = OPW'(14);
    localparam logic [OPW-1:0] ALU_BGEU = OPW'(15);

    logic [6:0]     w_opc;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    logic [OPW-1:0] w_op;
    logic           w_imm;
    logic           w_br;
    logic           w_ill;
    logic [OPW-1:0] w_f3_op;
    logic           w_unused;

    assign w_opc    = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_unused = ^{in_instr[24:15], in_instr[11:7]};

    // Shared funct3 -> op map for register and immediate arithmetic.
    always_comb begin
        w_f3_op = ALU_ADD;
        case (w_f3)
            3'b000:  w_f3_op = ALU_ADD;
            3'b001:  w_f3_op = ALU_SLL;
            3'b010:  w_f3_op = ALU_SLT;
            3'b011:  w_f3_op = ALU_SLTU;
            3'b100:  w_f3_op = ALU_XOR;
            3'b101:  w_f3_op = ALU_SRL;
            3'b110:  w_f3_op = ALU_OR;
            default: w_f3_op = ALU_AND;
        endcase
    end

    always_comb begin
        w_op  = ALU_ADD;
        w_imm = 1'b0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (w_opc)
            OPC_R: begin
                if (w_f7 == F7_ZERO)                        w_op = w_f3_op;
                else if (w_f7 == F7_ALT && w_f3 == 3'b000)  w_op = ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'b101)  w_op = ALU_SRA;
                else                                        w_ill = 1'b1;
            end
            OPC_I: begin
                w_imm = 1'b1;
                w_op  = w_f3_op;
                // Only the shift forms constrain the upper immediate bits.
                if (w_f3 == 3'b001 && w_f7 != F7_ZERO) w_ill = 1'b1;
                if (w_f3 == 3'b101) begin
                    if (w_f7 == F7_ALT)       w_op  = ALU_SRA;
                    else if (w_f7 != F7_ZERO) w_ill = 1'b1;
                end
            end
            OPC_BR: begin
                w_br = 1'b1;
                case (w_f3)
                    3'b000:  w_op = ALU_BEQ;
                    3'b001:  w_op = ALU_BNE;
                    3'b100:  w_op = ALU_BLT;
                    3'b101:  w_op = ALU_BGE;
                    3'b110:  w_op = ALU_BLTU;
                    3'b111:  w_op = ALU_BGEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LD, OPC_ST, OPC_AUI, OPC_LUI, OPC_JAL: w_imm = 1'b1;
            OPC_JALR: begin
                w_imm = 1'b1;
                if (w_f3 != 3'b000) w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_op  = ALU_ADD;
            w_imm = 1'b0;
            w_br  = 1'b0;
        end
    end

    logic [EW-1:0] r_mem [DEPTH];
    logic          r_head;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_tail;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head_entry;

    assign in_ready     = (r_count < 2'(DEPTH));
    assign out_valid    = (r_count != 2'd0);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_tail       = r_head ^ r_count[0];
    assign w_entry      = {w_op, w_imm, w_br, w_ill};
    assign w_head_entry = out_valid ? r_mem[r_head] : '0;

    assign {out_alu_op, out_use_imm, out_is_branch, out_illegal} = w_head_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            if (w_push) r_mem[w_tail] <= w_entry;
            if (w_pop)  r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_dec.sv
// Directed plus randomized bench for alu_ctrl_dec against a queue-based decode model.
module tb_alu_ctrl_dec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_alu_op;
    logic        out_use_imm;
    logic        out_is_branch;
    logic        out_illegal;

    int checks = 0;
    int failures = 0;
    logic [7:0] mq[$];

    alu_ctrl_dec #(.DEPTH(2), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_use_imm(out_use_imm),
        .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model result packed as {alu_op[4:0], use_imm, is_branch, illegal}.
    function automatic logic [7:0] mdl(input logic [31:0] w);
        int alu_of_f3[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int br_of_f3[8]  = '{10, 11, -1, -1, 12, 13, 14, 15};
        int op = 0;
        bit imm = 0, br = 0, ill = 0;
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        case (w[6:0])
            7'h33: begin
                if (f7 == 0) op = alu_of_f3[f3];
                else if (f7 == 32 && f3 == 0) op = 1;
                else if (f7 == 32 && f3 == 5) op = 7;
                else ill = 1;
            end
            7'h13: begin
                imm = 1;
                op = alu_of_f3[f3];
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5 && f7 == 32) op = 7;
                if (f3 == 5 && f7 != 0 && f7 != 32) ill = 1;
            end
            7'h63: begin
                if (br_of_f3[f3] < 0) ill = 1;
                else begin op = br_of_f3[f3]; br = 1; end
            end
            7'h03, 7'h23, 7'h17, 7'h37, 7'h6F: imm = 1;
            7'h67: if (f3 == 0) imm = 1; else ill = 1;
            default: ill = 1;
        endcase
        if (ill) return 8'h01;
        return {5'(op), imm, br, 1'b0};
    endfunction

    always @(negedge rst_n) mq.delete();

    always @(posedge clk) begin
        bit push, pop;
        if (rst_n) begin
            if (flush) mq.delete();
            else begin
                pop  = (mq.size() != 0) && out_ready;
                push = in_valid && (mq.size() < 2);
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(mdl(in_instr));
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check("head", 32'({out_alu_op, out_use_imm, out_is_branch, out_illegal}),
              32'((mq.size() != 0) ? mq[0] : 8'h00));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom();
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h63;
            3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h17;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h6F;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    logic [7:0] head_now;
    assign head_now = {out_alu_op, out_use_imm, out_is_branch, out_illegal};

    logic [31:0] vec_i [10] = '{32'h002081B3, 32'h40208133, 32'h4020D133, 32'h4030D093,
                                32'h00209463, 32'h0000A103, 32'h40209133, 32'h0020A063,
                                32'hFFFFFFFF, 32'h00209133};
    logic [7:0]  vec_e [10] = '{8'h00, 8'h08, 8'h38, 8'h3C, 8'h5A, 8'h04,
                                8'h01, 8'h01, 8'h01, 8'h10};

    initial begin
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_head", 32'(head_now), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;

        // First push after reset; visible one edge later.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_head", 32'(head_now), 32'h00);
        out_ready = 1'b1;
        tick();

        // Decode sweep in streaming mode: each push replaces the popped head.
        for (int i = 0; i < 10; i++) begin
            check("model_pin", 32'(mdl(vec_i[i])), 32'(vec_e[i]));
            in_instr = vec_i[i];
            in_valid = 1'b1;
            tick();
            check("sweep_head", 32'(head_now), 32'(vec_e[i]));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: three offered, two accepted.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = vec_i[i];
            tick();
        end
        in_valid = 1'b0;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head0", 32'(head_now), 32'h00);
        out_ready = 1'b1;
        tick();
        check("bp_ready_back", 32'(in_ready), 32'd1);
        check("bp_head1", 32'(head_now), 32'h08);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Sustained push+pop at one entry.
        in_valid = 1'b1;
        repeat (10) begin
            in_instr = rnd_instr();
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Flush with a full queue and a concurrent push.
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_empty", 32'(out_valid), 32'd0);
        tick();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Async reset with a full queue clears outputs without a clock edge.
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        check("full_before_rst", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(out_valid), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rnd_instr();
            flush     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 400) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
